// File: rtl/hour_bcd_counter.sv
// Hour counter with BCD digits, optional 12-hour AM/PM mode, prescaled auto-tick
// and registered seven-segment outputs for both digits.
module hour_bcd_counter #(
  parameter int DIV_N    = 10,
  parameter bit MODE_12H = 1'b0
) (
  input  logic       clk_in,
  input  logic       rst,
  input  logic       en,
  input  logic       inc,
  input  logic       load,
  input  logic [3:0] load_tens,
  input  logic [3:0] load_ones,
  input  logic       load_pm,
  output logic [7:0] seg_data1,
  output logic [7:0] seg_data2,
  output logic       pm,
  output logic       carry,
  output logic       load_err
);

  localparam int            PW        = (DIV_N > 1) ? $clog2(DIV_N) : 1;
  localparam logic [PW-1:0] PRESC_MAX = PW'(DIV_N - 1);
  localparam logic [PW-1:0] PRESC_ONE = PW'(1);

  localparam logic [1:0] RST_TENS = MODE_12H ? 2'd1 : 2'd0;
  localparam logic [3:0] RST_ONES = MODE_12H ? 4'd2 : 4'd0;
  localparam logic [7:0] RST_SEG1 = MODE_12H ? 8'hDA : 8'hFC;
  localparam logic [7:0] RST_SEG2 = MODE_12H ? 8'h60 : 8'hFC;

  logic [PW-1:0] presc_q;
  logic          tick;
  logic [1:0]    tens_q;
  logic [3:0]    ones_q;
  logic          pm_q;

  logic [1:0]    inc_tens;
  logic [3:0]    inc_ones;
  logic          inc_pm;
  logic          inc_carry;
  logic          load_ok;
  logic [7:0]    ones_seg;
  logic [7:0]    tens_seg;

  function automatic logic [7:0] seg_encode(input logic [3:0] digit);
    logic [7:0] code;
    case (digit)
      4'd0:    code = 8'hFC;
      4'd1:    code = 8'h60;
      4'd2:    code = 8'hDA;
      4'd3:    code = 8'hF2;
      4'd4:    code = 8'h66;
      4'd5:    code = 8'hB6;
      4'd6:    code = 8'hBE;
      4'd7:    code = 8'hE0;
      4'd8:    code = 8'hFE;
      4'd9:    code = 8'hF6;
      default: code = 8'h00;
    endcase
    return code;
  endfunction

  assign tick = en && (presc_q == PRESC_MAX);
  assign pm   = pm_q;

  // Next count after one increment; 12h mode flips AM/PM on 11->12 only.
  always_comb begin
    inc_tens  = tens_q;
    inc_ones  = ones_q + 4'd1;
    inc_pm    = pm_q;
    inc_carry = 1'b0;
    if (MODE_12H) begin
      if (tens_q == 2'd1 && ones_q == 4'd2) begin
        inc_tens = 2'd0;
        inc_ones = 4'd1;
      end else if (tens_q == 2'd1 && ones_q == 4'd1) begin
        inc_ones  = 4'd2;
        inc_pm    = ~pm_q;
        inc_carry = pm_q;
      end else if (ones_q == 4'd9) begin
        inc_tens = tens_q + 2'd1;
        inc_ones = 4'd0;
      end
    end else begin
      if (tens_q == 2'd2 && ones_q == 4'd3) begin
        inc_tens  = 2'd0;
        inc_ones  = 4'd0;
        inc_carry = 1'b1;
      end else if (ones_q == 4'd9) begin
        inc_tens = tens_q + 2'd1;
        inc_ones = 4'd0;
      end
    end
  end

  always_comb begin
    load_ok = 1'b0;
    if (load_ones <= 4'd9) begin
      if (MODE_12H)
        load_ok = (load_tens == 4'd0 && load_ones != 4'd0) ||
                  (load_tens == 4'd1 && load_ones <= 4'd2);
      else
        load_ok = (load_tens <= 4'd1) ||
                  (load_tens == 4'd2 && load_ones <= 4'd3);
    end
  end

  always_comb begin
    ones_seg = seg_encode(ones_q);
    tens_seg = seg_encode({2'b00, tens_q});
  end

  // Displays trail the count by one edge; reset loads them directly.
  always_ff @(posedge clk_in) begin
    if (!rst) begin
      presc_q   <= '0;
      tens_q    <= RST_TENS;
      ones_q    <= RST_ONES;
      pm_q      <= 1'b0;
      carry     <= 1'b0;
      load_err  <= 1'b0;
      seg_data1 <= RST_SEG1;
      seg_data2 <= RST_SEG2;
    end else begin
      if (en)
        presc_q <= (presc_q == PRESC_MAX) ? '0 : presc_q + PRESC_ONE;
      carry     <= 1'b0;
      load_err  <= 1'b0;
      seg_data1 <= {ones_seg[7:1], pm_q};
      seg_data2 <= tens_seg;
      if (load) begin
        if (load_ok) begin
          tens_q <= load_tens[1:0];
          ones_q <= load_ones;
          pm_q   <= MODE_12H ? load_pm : 1'b0;
        end else begin
          load_err <= 1'b1;
        end
      end else if (tick || inc) begin
        tens_q <= inc_tens;
        ones_q <= inc_ones;
        pm_q   <= inc_pm;
        carry  <= inc_carry;
      end
    end
  end

endmodule

// File: tb/tb_hour_bcd_counter.sv
// Scoreboard bench: runs a 24h and a 12h instance on shared stimulus against an
// integer-hour reference model, plus a few directed constant checks.
module tb_hour_bcd_counter;

  localparam int DIV = 10;

  typedef struct packed {
    logic [7:0] seg1;
    logic [7:0] seg2;
    logic       pm;
    logic       carry;
    logic       err;
  } obs_t;

  typedef struct {
    int   presc;
    int   hour;
    bit   pm;
    obs_t out;
  } model_t;

  logic       clk_in = 1'b0;
  logic       rst = 1'b0;
  logic       en = 1'b0;
  logic       inc = 1'b0;
  logic       load = 1'b0;
  logic [3:0] load_tens = 4'd0;
  logic [3:0] load_ones = 4'd0;
  logic       load_pm = 1'b0;

  logic [7:0] seg1_24, seg2_24, seg1_12, seg2_12;
  logic       pm24, carry24, err24, pm12, carry12, err12;

  int checks = 0;
  int failures = 0;

  model_t m24 = '{0, 0, 1'b0, '0};
  model_t m12 = '{0, 12, 1'b0, '0};
  obs_t   exp24_q[$];
  obs_t   exp12_q[$];

  hour_bcd_counter #(.DIV_N(DIV), .MODE_12H(1'b0)) dut24 (
    .clk_in(clk_in), .rst(rst), .en(en), .inc(inc), .load(load),
    .load_tens(load_tens), .load_ones(load_ones), .load_pm(load_pm),
    .seg_data1(seg1_24), .seg_data2(seg2_24), .pm(pm24), .carry(carry24),
    .load_err(err24)
  );

  hour_bcd_counter #(.DIV_N(DIV), .MODE_12H(1'b1)) dut12 (
    .clk_in(clk_in), .rst(rst), .en(en), .inc(inc), .load(load),
    .load_tens(load_tens), .load_ones(load_ones), .load_pm(load_pm),
    .seg_data1(seg1_12), .seg_data2(seg2_12), .pm(pm12), .carry(carry12),
    .load_err(err12)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [7:0] digit_code(input int d);
    logic [7:0] table_v [10] = '{8'hFC, 8'h60, 8'hDA, 8'hF2, 8'h66,
                                 8'hB6, 8'hBE, 8'hE0, 8'hFE, 8'hF6};
    return table_v[d];
  endfunction

  // Reference works on plain integer hours, not BCD digits.
  function automatic model_t model_step(input model_t s, input bit mode12,
                                        input logic r, e, i, l,
                                        input logic [3:0] lt, lo,
                                        input logic lp);
    model_t n = s;
    int     val;
    bit     ok;
    bit     tick;
    if (!r) begin
      n.presc     = 0;
      n.hour      = mode12 ? 12 : 0;
      n.pm        = 1'b0;
      n.out.carry = 1'b0;
      n.out.err   = 1'b0;
      n.out.seg1  = mode12 ? 8'hDA : 8'hFC;
      n.out.seg2  = mode12 ? 8'h60 : 8'hFC;
      n.out.pm    = 1'b0;
      return n;
    end
    n.out.seg1  = (digit_code(s.hour % 10) & 8'hFE) | {7'd0, s.pm};
    n.out.seg2  = digit_code(s.hour / 10);
    n.out.carry = 1'b0;
    n.out.err   = 1'b0;
    tick = e && (s.presc == DIV - 1);
    if (e) n.presc = (s.presc + 1) % DIV;
    if (l) begin
      val = int'(lt) * 10 + int'(lo);
      ok  = (lt <= 4'd9) && (lo <= 4'd9) &&
            (mode12 ? (val >= 1 && val <= 12) : (val <= 23));
      if (ok) begin
        n.hour = val;
        n.pm   = mode12 ? lp : 1'b0;
      end else begin
        n.out.err = 1'b1;
      end
    end else if (tick || i) begin
      if (mode12) begin
        if (s.hour == 11) begin
          n.hour      = 12;
          n.pm        = !s.pm;
          n.out.carry = s.pm;
        end else if (s.hour == 12) begin
          n.hour = 1;
        end else begin
          n.hour = s.hour + 1;
        end
      end else begin
        n.hour      = (s.hour + 1) % 24;
        n.out.carry = (s.hour == 23);
      end
    end
    n.out.pm = n.pm;
    return n;
  endfunction

  task automatic checkOutput(input string tag, input logic [7:0] actual,
                             input logic [7:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s actual=%h expected=%h at %0t", tag, actual, expected, $time);
    end
  endtask

  task automatic applyStimulus(input logic r, e, i, l,
                               input logic [3:0] lt, lo, input logic lp);
    obs_t e24, e12;
    rst = r; en = e; inc = i; load = l;
    load_tens = lt; load_ones = lo; load_pm = lp;
    @(posedge clk_in);
    m24 = model_step(m24, 1'b0, r, e, i, l, lt, lo, lp);
    m12 = model_step(m12, 1'b1, r, e, i, l, lt, lo, lp);
    exp24_q.push_back(m24.out);
    exp12_q.push_back(m12.out);
    @(negedge clk_in);
    e24 = exp24_q.pop_front();
    e12 = exp12_q.pop_front();
    checkOutput("seg1_24", seg1_24, e24.seg1);
    checkOutput("seg2_24", seg2_24, e24.seg2);
    checkOutput("pm_24", 8'(pm24), 8'(e24.pm));
    checkOutput("carry_24", 8'(carry24), 8'(e24.carry));
    checkOutput("err_24", 8'(err24), 8'(e24.err));
    checkOutput("seg1_12", seg1_12, e12.seg1);
    checkOutput("seg2_12", seg2_12, e12.seg2);
    checkOutput("pm_12", 8'(pm12), 8'(e12.pm));
    checkOutput("carry_12", 8'(carry12), 8'(e12.carry));
    checkOutput("err_12", 8'(err12), 8'(e12.err));
  endtask

  task automatic idle(input logic e, input int n);
    for (int k = 0; k < n; k++) applyStimulus(1'b1, e, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
  endtask

  initial begin
    int c24;
    int c12;
    logic [3:0] bad_t [6] = '{4'd2, 4'd1, 4'd0, 4'd0, 4'd3, 4'd10};
    logic [3:0] bad_o [6] = '{4'd4, 4'd3, 4'd0, 4'd10, 4'd0, 4'd0};

    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd1, 4'd1, 1'b1);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("reset_seg1_24", seg1_24, 8'hFC);
    checkOutput("reset_seg1_12", seg1_12, 8'hDA);
    checkOutput("reset_seg2_12", seg2_12, 8'h60);

    // A full day of prescaled ticks: exactly one day carry in each mode.
    c24 = 0;
    c12 = 0;
    for (int k = 0; k < 24 * DIV; k++) begin
      applyStimulus(1'b1, 1'b1, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
      if (carry24) c24++;
      if (carry12) c12++;
    end
    checkOutput("day_carry_count_24", 8'(c24), 8'd1);
    checkOutput("day_carry_count_12", 8'(c12), 8'd1);

    // 11 PM -> 12 AM carries, 12 -> 01 does not.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd1, 4'd1, 1'b1);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("pm_roll_carry", 8'(carry12), 8'd1);
    checkOutput("pm_roll_pm", 8'(pm12), 8'd0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    checkOutput("twelve_to_one_carry", 8'(carry12), 8'd0);
    idle(1'b0, 1);
    checkOutput("one_am_seg1", seg1_12, 8'h60);
    checkOutput("one_am_seg2", seg2_12, 8'hFC);

    foreach (bad_t[k]) begin
      applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, bad_t[k], bad_o[k], 1'b0);
      idle(1'b0, 1);
    end
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd2, 4'd4, 1'b0);
    checkOutput("load24_err", 8'(err24), 8'd1);
    idle(1'b0, 1);
    checkOutput("load24_err_single", 8'(err24), 8'd0);

    // Tick and inc together at 09 give one step, to 10.
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b0, 4'd0, 4'd0, 1'b0);
    applyStimulus(1'b1, 1'b1, 1'b0, 1'b1, 4'd0, 4'd9, 1'b0);
    idle(1'b1, 8);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    idle(1'b1, 1);
    checkOutput("tick_inc_tens", seg2_24, 8'h60);
    checkOutput("tick_inc_ones", seg1_24, 8'hFC);

    // Load wins over a coincident inc.
    applyStimulus(1'b1, 1'b0, 1'b0, 1'b1, 4'd0, 4'd5, 1'b0);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b1, 4'd1, 4'd7, 1'b0);
    idle(1'b0, 1);
    checkOutput("load_inc_tens", seg2_24, 8'h60);
    checkOutput("load_inc_ones", seg1_24, 8'hE0);

    // Freeze with en=0, manual incs still count, then reset mid-prescale.
    idle(1'b0, 20);
    applyStimulus(1'b1, 1'b0, 1'b1, 1'b0, 4'd0, 4'd0, 1'b0);
    idle(1'b0, 29);
    idle(1'b1, 7);
    applyStimulus(1'b0, 1'b1, 1'b1, 1'b1, 4'd0, 4'd3, 1'b0);
    idle(1'b1, 12);

    for (int k = 0; k < 300; k++) begin
      applyStimulus(($urandom_range(0, 40) != 0), ($urandom_range(0, 3) != 0),
                    ($urandom_range(0, 4) == 0), ($urandom_range(0, 6) == 0),
                    4'($urandom_range(0, 3)), 4'($urandom_range(0, 11)),
                    1'($urandom_range(0, 1)));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/hour_bcd_counter.md
HOUR_BCD_COUNTER -- requirements
Module: hour_bcd_counter

Interface
REQ-001 SHALL have parameter DIV_N, default 10: prescaler ratio, clk_in cycles per hour-tick, legal range 2..2^20.
REQ-002 SHALL have parameter MODE_12H, default 0: 0 = 24-hour count 00..23; 1 = 12-hour count 01..12 with AM/PM flag.
REQ-003 SHALL have port clk_in, input, 1 bit: single clock for all logic.
REQ-004 SHALL have port rst, input, 1 bit: reset is synchronous and active-low.
REQ-005 SHALL have port en, input, 1 bit: 1 = prescaler runs; 0 = prescaler and auto-increment frozen.
REQ-006 SHALL have port inc, input, 1 bit: one-cycle manual increment request.
REQ-007 SHALL have port load, input, 1 bit: one-cycle request to preset the count.
REQ-008 SHALL have port load_tens, input, 4 bits: BCD tens value for load.
REQ-009 SHALL have port load_ones, input, 4 bits: BCD ones value for load.
REQ-010 SHALL have port load_pm, input, 1 bit: PM value for load; ignored when MODE_12H=0.
REQ-011 SHALL have port seg_data1, output, 8 bits: ones-digit segments {a,b,c,d,e,f,g,dp}, active-high.
REQ-012 SHALL have port seg_data2, output, 8 bits: tens-digit segments, same encoding as seg_data1.
REQ-013 SHALL have port pm, output, 1 bit: 1 = PM; held at 0 when MODE_12H=0.
REQ-014 SHALL have port carry, output, 1 bit: one-cycle day-rollover pulse.
REQ-015 SHALL have port load_err, output, 1 bit: one-cycle pulse when a load is rejected.

Function
REQ-016 Prescaler:
- SHALL count 0..DIV_N-1 while en=1, wrapping to 0.
- SHALL assert an internal tick for exactly the one cycle in which it holds DIV_N-1.
- SHALL hold its value while en=0.
REQ-017 Count register SHALL be two BCD digits: tens (2 bits significant), ones (4 bits); it never holds a non-BCD or out-of-range value.
REQ-018 Increment event SHALL be (tick OR inc); tick and inc in the same cycle SHALL produce exactly one increment.
REQ-019 inc SHALL be honoured regardless of en.
REQ-020 Priority per cycle SHALL be: rst, then load, then increment; an increment coinciding with a load is discarded.
REQ-021 24-hour increment SHALL advance ones 0..9; at 9, ones->0 and tens+1; at 23, wrap to 00.
REQ-022 24-hour wrap 23->00 SHALL pulse carry for one cycle, coincident with the count update.
REQ-023 12-hour increment SHALL follow sequence 12,01,02,...,11,12; 09->10 carries into tens.
REQ-024 12-hour, 11->12 SHALL toggle pm; carry SHALL pulse only when pm goes 1->0 (11 PM -> 12 AM).
REQ-025 12-hour, 12->01 SHALL NOT toggle pm and SHALL NOT pulse carry.
REQ-026 Load SHALL be accepted only when load_tens and load_ones are BCD and the value is in range: 00..23 (24h) or 01..12 (12h).
REQ-027 Accepted load SHALL update count (and pm in 12h mode) on the next edge; load itself SHALL NOT pulse carry.
REQ-028 Rejected load SHALL leave count and pm unchanged and pulse load_err for one cycle.
REQ-029 seg_data1/seg_data2 SHALL be registered: they reflect the count one cycle after the count register changes.
REQ-030 Segment codes SHALL be (dp=0): 0=FC, 1=60, 2=DA, 3=F2, 4=66, 5=B6, 6=BE, 7=E0, 8=FE, 9=F6 (hex).
REQ-031 seg_data1 dp SHALL mirror pm; seg_data2 dp SHALL be 0.
REQ-032 carry and load_err SHALL be registered single-cycle pulses, never asserted two consecutive cycles from one event.

Reset
REQ-033 On rst=0 at a clk_in edge, the prescaler SHALL clear to 0.
REQ-034 On reset, count SHALL become 00 (24h) or 12 with pm=0 (12h).
REQ-035 On reset, carry=0 and load_err=0.
REQ-036 On reset, seg_data1/seg_data2 SHALL show the reset count on the same edge (24h: FC/FC; 12h: DA/60).
REQ-037 Reset mid-count SHALL discard any pending tick, inc or load in that cycle; counting resumes from the reset state with the prescaler at 0.

Verification
REQ-038 DIV_N=10, MODE_12H=0, en=1, from reset: first increment on cycle 10; 24 ticks -> count returns 00; carry high exactly one cycle at the 23->00 edge.
REQ-039 MODE_12H=1: load 11/pm=1, then inc -> 12, pm=0, carry=1 one cycle; next inc -> 01, pm=0, carry=0.
REQ-040 Load 24 (24h) or 13, 00, or tens=0/ones=A (12h) -> load_err one cycle; count unchanged.
REQ-041 inc coincident with tick at count 09 (24h) -> count 10, not 11.
REQ-042 Load together with inc at count 05 with load=17 -> count 17; seg_data2=60 and seg_data1=E0 one cycle later.
REQ-043 en=0 for 50 cycles -> count and prescaler frozen; inc still increments; rst=0 at prescaler=7 -> next tick after 10 cycles.
